// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader
//   Serves hps_io upload reads (hiscore / NVRAM save) from a core-side RAM
//   port that is shared with the game CPU through an arbiter. Each accepted
//   ioctl_rd issues one arbitrated RAM read and holds ioctl_wait high until
//   the byte is on ioctl_din.
//
// Ports
//   clk_sys, reset_n             clock, synchronous active-low reset
//   ioctl_upload, ioctl_index    session enable and selected upload index
//   ioctl_rd, ioctl_addr         read strobe and 25-bit byte address
//   ioctl_din, ioctl_wait        returned byte, stall towards hps_io
//   mem_req, mem_addr, mem_gnt   arbitrated RAM read request
//   mem_q                        RAM read data, valid RD_LAT cycles after grant
//   busy                         a read is in flight
//   rd_overrun                   sticky: ioctl_rd arrived while busy
//
// Build option
//   UPLOAD_CKSUM_EN: keep an 8-bit sum of the bytes returned this session and
//   return it for a read of address SIZE.
module ioctl_upload_reader #(
  parameter logic [7:0]  INDEX  = 8'd4,
  parameter int unsigned AW     = 12,
  parameter int unsigned SIZE   = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic [7:0]    mem_q,
  output logic          busy,
  output logic          rd_overrun
);

  localparam int unsigned CW     = 2;
  localparam logic [24:0] SIZE_A = 25'(SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_LAT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      din_q, din_d;
  logic            wait_q, wait_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic            sel_c;
  logic [7:0]      oob_c;

`ifdef UPLOAD_CKSUM_EN
  logic            sel_q;
  logic [7:0]      sum_q, sum_d;

  // Address SIZE reads back the session checksum, anything above is blank.
  assign oob_c = (ioctl_addr == SIZE_A) ? sum_q : 8'hFF;
`else
  assign oob_c = 8'hFF;
`endif

  assign sel_c = ioctl_upload & (ioctl_index == INDEX);

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ovr_d   = ovr_q;
`ifdef UPLOAD_CKSUM_EN
    sum_d   = sum_q;
    if (sel_c && !sel_q) sum_d = 8'h00;
`endif

    if (ioctl_rd && sel_c && (state_q != ST_IDLE)) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sel_c && ioctl_rd) begin
          if (ioctl_addr < SIZE_A) begin
            addr_d  = ioctl_addr[AW-1:0];
            req_d   = 1'b1;
            wait_d  = 1'b1;
            state_d = ST_REQ;
          end else begin
            din_d = oob_c;
          end
        end
      end
      ST_REQ: begin
        // Losing the session abandons the read; ioctl_din is left alone.
        if (!sel_c) begin
          req_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (mem_gnt) begin
          cnt_d   = CW'(RD_LAT - 1);
          req_d   = 1'b0;
          state_d = ST_LAT;
        end
      end
      ST_LAT: begin
        if (!sel_c) begin
          wait_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          din_d   = mem_q;
          wait_d  = 1'b0;
          state_d = ST_IDLE;
`ifdef UPLOAD_CKSUM_EN
          sum_d   = sum_q + mem_q;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        wait_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= 8'hFF;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UPLOAD_CKSUM_EN
      sel_q   <= 1'b0;
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef UPLOAD_CKSUM_EN
      sel_q   <= sel_c;
      sum_q   <= sum_d;
`endif
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;
  assign rd_overrun = ovr_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Testbench for ioctl_upload_reader: a RAM model behind a controllable
// arbiter grant, a driver issuing directed and random upload reads, and a
// monitor that pops the expected byte each time ioctl_wait falls.
module tb_ioctl_upload_reader;

  localparam int unsigned AW     = 12;
  localparam int unsigned SIZE   = 1024;
  localparam int unsigned RD_LAT = 1;
  localparam logic [7:0]  INDEX  = 8'd4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b1;
  logic [7:0]    mem_q = 8'h00;
  logic          busy;
  logic          rd_overrun;

  ioctl_upload_reader #(
    .INDEX(INDEX), .AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_q(mem_q),
    .busy(busy), .rd_overrun(rd_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] ram [0:(1<<AW)-1];
  int         checks = 0;
  int         errors = 0;
  int         gnt_mode = 1;   // 0 low, 1 high, 2 random
  logic [7:0] exp_q [$];
  logic [7:0] last_din = 8'hFF;
  logic [7:0] sum_m = 8'h00;
  logic       sel_m = 1'b0;
  logic       ovr_m = 1'b0;
  logic       prev_wait = 1'b0;
  logic [7:0] mon_e;

  // Arbiter grant changes away from the sampling edge.
  always @(negedge clk_sys)
    mem_gnt <= (gnt_mode == 2) ? 1'($urandom) : (gnt_mode == 1);

  // RAM with one cycle read latency; data is garbage outside the valid cycle.
  always @(posedge clk_sys)
    mem_q <= (mem_req && mem_gnt) ? ram[mem_addr] : 8'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every falling ioctl_wait is a completed (or dropped) read.
  always @(negedge clk_sys) begin
    if (prev_wait && !ioctl_wait) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: wait fell with din %0h and no expectation at %0t", ioctl_din, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_din", 32'(ioctl_din), 32'(mon_e));
        chk("sb_req_low", 32'(mem_req), 0);
        chk("sb_busy_low", 32'(busy), 0);
      end
    end
    prev_wait <= ioctl_wait;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_sel(input logic up, input logic [7:0] idx);
    logic s;
    ioctl_upload = up;
    ioctl_index  = idx;
    s = up && (idx == INDEX);
    if (s && !sel_m) sum_m = 8'h00;
    sel_m = s;
  endtask

  task automatic pulse(input int unsigned a);
    ioctl_addr = 25'(a);
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
  endtask

  function automatic logic [7:0] oob_exp(input int unsigned a);
`ifdef UPLOAD_CKSUM_EN
    if (a == SIZE) return sum_m;
`endif
    return 8'hFF;
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, 32'(ioctl_wait), 0);
  endtask

  task automatic read_in(input int unsigned a, input bit extra);
    logic [7:0] d;
    d = ram[a[AW-1:0]];
    exp_q.push_back(d);
    pulse(a);
    if (extra) begin
      pulse($urandom_range(SIZE - 1));
      ovr_m = 1'b1;
    end
    wait_done("rd_in");
    last_din = d;
    sum_m    = sum_m + d;
    chk("overrun_flag", 32'(rd_overrun), 32'(ovr_m));
  endtask

  task automatic read_oob(input int unsigned a);
    logic [7:0] e;
    e = oob_exp(a);
    pulse(a);
    chk("oob_din", 32'(ioctl_din), 32'(e));
    chk("oob_no_wait", 32'(ioctl_wait), 0);
    chk("oob_no_req", 32'(mem_req), 0);
    last_din = e;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_din"}, 32'(ioctl_din), 32'hFF);
    chk({tag, "_wait"}, 32'(ioctl_wait), 0);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovr"}, 32'(rd_overrun), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
    ram[0] = 8'h5A;
    ram[3] = 8'hC3;
    reset_n = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    set_sel(1'b0, 8'd0);
    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Immediate grant: request for one cycle, data from cycle 3.
    set_sel(1'b1, INDEX);
    tick();
    exp_q.push_back(8'h5A);
    pulse(0);
    chk("t1_c1_req", 32'(mem_req), 1);
    chk("t1_c1_wait", 32'(ioctl_wait), 1);
    chk("t1_c1_busy", 32'(busy), 1);
    tick();
    chk("t1_c2_req", 32'(mem_req), 0);
    chk("t1_c2_wait", 32'(ioctl_wait), 1);
    tick();
    chk("t1_c3_din", 32'(ioctl_din), 32'h5A);
    chk("t1_c3_wait", 32'(ioctl_wait), 0);
    last_din = 8'h5A;
    sum_m = sum_m + 8'h5A;

    // Grant withheld for five cycles.
    gnt_mode = 0;
    exp_q.push_back(8'hC3);
    pulse(3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_held", 32'(mem_req), 1);
      chk("t2_addr_held", 32'(mem_addr), 3);
      chk("t2_wait_held", 32'(ioctl_wait), 1);
      tick();
    end
    gnt_mode = 1;
    tick();
    chk("t2_lat_wait", 32'(ioctl_wait), 1);
    chk("t2_lat_din_old", 32'(ioctl_din), 32'h5A);
    tick();
    chk("t2_din", 32'(ioctl_din), 32'hC3);
    chk("t2_wait_low", 32'(ioctl_wait), 0);
    last_din = 8'hC3;
    sum_m = sum_m + 8'hC3;

    // Out-of-range addresses, including one whose low bits alias a valid byte.
    read_oob(SIZE);
    tick();
    chk("t3_no_wait_later", 32'(ioctl_wait), 0);
    chk("t3_no_req_later", 32'(mem_req), 0);
    read_oob(SIZE + 1);
    read_oob((1 << AW) | 3);
    read_oob(25'h1000005);

    // Second strobe while the first read waits for grant.
    gnt_mode = 0;
    exp_q.push_back(ram[7]);
    pulse(7);
    pulse(9);
    ovr_m = 1'b1;
    chk("t4_ovr_set", 32'(rd_overrun), 1);
    chk("t4_addr_kept", 32'(mem_addr), 7);
    gnt_mode = 1;
    wait_done("t4");
    last_din = ram[7];
    sum_m = sum_m + ram[7];
    tick();
    chk("t4_din", 32'(ioctl_din), 32'(ram[7]));
    chk("t4_ovr_sticky", 32'(rd_overrun), 1);

    // Session drops while the RAM data is in flight.
    exp_q.push_back(last_din);
    pulse(11);
    tick();
    set_sel(1'b0, INDEX);
    tick();
    chk("t5_req", 32'(mem_req), 0);
    chk("t5_wait", 32'(ioctl_wait), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_din_kept", 32'(ioctl_din), 32'(last_din));
    set_sel(1'b1, INDEX);
    tick();

    // Random traffic with random grant.
    gnt_mode = 2;
    for (int it = 0; it < 300; it++) begin
      int unsigned r;
      r = $urandom_range(9);
      if (r == 0) begin
        set_sel(1'($urandom), INDEX ^ 8'($urandom_range(254) + 1));
        pulse($urandom_range(SIZE - 1));
        chk("rnd_nosel_wait", 32'(ioctl_wait), 0);
        chk("rnd_nosel_req", 32'(mem_req), 0);
        chk("rnd_nosel_din", 32'(ioctl_din), 32'(last_din));
        set_sel(1'b1, INDEX);
      end else if (r == 1) begin
        read_oob(($urandom_range(3) == 0) ? SIZE : SIZE + $urandom_range(1 << 24));
      end else begin
        read_in($urandom_range(SIZE - 1), ($urandom_range(7) == 0));
      end
    end
    gnt_mode = 1;
    tick();

    // Mismatched index gets nothing; then reset while a read waits for grant.
    set_sel(1'b1, 8'd3);
    pulse(5);
    chk("t6_idx_wait", 32'(ioctl_wait), 0);
    chk("t6_idx_req", 32'(mem_req), 0);
    chk("t6_idx_busy", 32'(busy), 0);
    tick();
    chk("t6_idx_din", 32'(ioctl_din), 32'(last_din));
    set_sel(1'b1, INDEX);
    tick();
    gnt_mode = 0;
    exp_q.push_back(8'hFF);
    pulse(5);
    tick();
    chk("t6_pre_req", 32'(mem_req), 1);
    reset_n = 1'b0;
    tick();
    check_reset_vals("t6_rst");
    ovr_m = 1'b0;
    last_din = 8'hFF;
    sum_m = 8'h00;
    reset_n = 1'b1;
    gnt_mode = 1;
    repeat (2) tick();

    // Post-reset read still works.
    read_in(3, 1'b0);
    repeat (4) tick();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
